// File: rtl/perf_trace_monitor_if.sv
// Snoop/status bundle between the core side and the performance trace monitor.
// master drives the snooped core activity and watch setup; slave is the monitor.
interface perf_trace_monitor_if #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
);
    logic              start_i;
    logic              clear_i;
    logic              retire_i;
    logic              stall_i;
    logic              flush_i;
    logic              wb_en_i;
    logic [REG_AW-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [REG_AW-1:0] watch_addr_i;
    logic [DATA_W-1:0] watch_val_i;
    logic              running_o;
    logic              done_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [CNT_W-1:0]  instr_cnt_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output start_i, clear_i, retire_i, stall_i, flush_i,
        output wb_en_i, wb_addr_i, wb_data_i, watch_addr_i, watch_val_i,
        input  running_o, done_o, cycle_cnt_o, instr_cnt_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, clear_i, retire_i, stall_i, flush_i,
        input  wb_en_i, wb_addr_i, wb_data_i, watch_addr_i, watch_val_i,
        output running_o, done_o, cycle_cnt_o, instr_cnt_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/perf_trace_monitor.sv
// Pipeline performance monitor: counts cycles/retires/stalls/flushes while running
// and freezes everything once the register/value watch sees a matching writeback.
module perf_trace_monitor #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter bit SAT_EN = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    perf_trace_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [REG_AW-1:0] wb_addr;
    logic [REG_AW-1:0] watch_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] watch_val;
    logic              hit;

    assign wb_addr    = mon.wb_addr_i;
    assign watch_addr = mon.watch_addr_i;
    assign wb_data    = mon.wb_data_i;
    assign watch_val  = mon.watch_val_i;

    // x0 is hardwired zero in the core, so a watch on it would never mean anything
    assign hit = (state == RUN) && mon.wb_en_i && (wb_addr == watch_addr) &&
                 (wb_addr != '0) && (wb_data == watch_val);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !(SAT_EN && (cnt == '1))) begin
            nxt = cnt + CNT_W'(1'b1);
        end
        return nxt;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mon.clear_i) begin
            state     <= IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mon.start_i) begin
            state     <= RUN;
            running   <= 1'b1;
            done      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            // the hit cycle itself is still counted before freezing
            cycle_cnt <= bump(cycle_cnt, 1'b1);
            instr_cnt <= bump(instr_cnt, mon.retire_i);
            stall_cnt <= bump(stall_cnt, mon.stall_i);
            flush_cnt <= bump(flush_cnt, mon.flush_i);
            if (hit) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign mon.running_o   = running;
    assign mon.done_o      = done;
    assign mon.cycle_cnt_o = cycle_cnt;
    assign mon.instr_cnt_o = instr_cnt;
    assign mon.stall_cnt_o = stall_cnt;
    assign mon.flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_perf_trace_monitor.sv
// Directed bench for perf_trace_monitor: main 32-bit instance plus two 4-bit
// instances (saturating and wrapping) sharing one small stimulus set.
module tb_perf_trace_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sm_start = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    perf_trace_monitor_if #(.CNT_W(32), .REG_AW(5), .DATA_W(32)) m_if ();
    perf_trace_monitor_if #(.CNT_W(4),  .REG_AW(5), .DATA_W(32)) s1_if ();
    perf_trace_monitor_if #(.CNT_W(4),  .REG_AW(5), .DATA_W(32)) s0_if ();

    perf_trace_monitor #(.CNT_W(32), .REG_AW(5), .DATA_W(32), .SAT_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .mon(m_if.slave));
    perf_trace_monitor #(.CNT_W(4), .REG_AW(5), .DATA_W(32), .SAT_EN(1'b1)) dut_sat (
        .clk_i(clk), .rst_i(rst), .mon(s1_if.slave));
    perf_trace_monitor #(.CNT_W(4), .REG_AW(5), .DATA_W(32), .SAT_EN(1'b0)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .mon(s0_if.slave));

    assign s1_if.start_i = sm_start;
    assign s1_if.clear_i = 1'b0;
    assign s1_if.retire_i = 1'b0;
    assign s1_if.stall_i = 1'b0;
    assign s1_if.flush_i = 1'b0;
    assign s1_if.wb_en_i = 1'b0;
    assign s1_if.wb_addr_i = '0;
    assign s1_if.wb_data_i = '0;
    assign s1_if.watch_addr_i = '0;
    assign s1_if.watch_val_i = '0;
    assign s0_if.start_i = sm_start;
    assign s0_if.clear_i = 1'b0;
    assign s0_if.retire_i = 1'b0;
    assign s0_if.stall_i = 1'b0;
    assign s0_if.flush_i = 1'b0;
    assign s0_if.wb_en_i = 1'b0;
    assign s0_if.wb_addr_i = '0;
    assign s0_if.wb_data_i = '0;
    assign s0_if.watch_addr_i = '0;
    assign s0_if.watch_val_i = '0;

    task automatic idle_inputs();
        m_if.start_i = 1'b0;  m_if.clear_i = 1'b0;
        m_if.retire_i = 1'b0; m_if.stall_i = 1'b0; m_if.flush_i = 1'b0;
        m_if.wb_en_i = 1'b0;  m_if.wb_addr_i = '0; m_if.wb_data_i = '0;
    endtask

    // one start pulse; returns on the negedge after the start edge (RUN, counts 0)
    task automatic pulse_start();
        @(negedge clk);
        m_if.start_i = 1'b1;
        @(negedge clk);
        m_if.start_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        m_if.clear_i = 1'b1;
        @(negedge clk);
        m_if.clear_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (m_if.running_o !== 1'b0 || m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd0 ||
            m_if.instr_cnt_o !== 32'd0 || m_if.stall_cnt_o !== 32'd0 || m_if.flush_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_init: run=%b done=%b cyc=%0d ins=%0d stl=%0d fl=%0d, want all 0",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o, m_if.instr_cnt_o,
                     m_if.stall_cnt_o, m_if.flush_cnt_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_start();
        m_if.retire_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.cycle_cnt_o !== 32'd3 || m_if.instr_cnt_o !== 32'd3) begin
            n_err++;
            $display("FAIL reset_prerun: run=%b cyc=%0d ins=%0d, want 1/3/3",
                     m_if.running_o, m_if.cycle_cnt_o, m_if.instr_cnt_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (m_if.running_o !== 1'b0 || m_if.done_o !== 1'b0 ||
            m_if.cycle_cnt_o !== 32'd0 || m_if.instr_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async_midrun: run=%b done=%b cyc=%0d ins=%0d, want 0/0/0/0",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o, m_if.instr_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_if.running_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stays_idle: run=%b cyc=%0d, want 0/0", m_if.running_o, m_if.cycle_cnt_o);
        end
        idle_inputs();
    endtask

    task automatic test_counting();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            m_if.retire_i = (i < 7);
            m_if.stall_i  = (i == 2 || i == 5 || i == 8);
            m_if.flush_i  = (i == 9);
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++;
        if (m_if.cycle_cnt_o !== 32'd10 || m_if.instr_cnt_o !== 32'd7 ||
            m_if.stall_cnt_o !== 32'd3 || m_if.flush_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL count_mix: cyc=%0d ins=%0d stl=%0d fl=%0d, want 10/7/3/1",
                     m_if.cycle_cnt_o, m_if.instr_cnt_o, m_if.stall_cnt_o, m_if.flush_cnt_o);
        end
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.done_o !== 1'b0) begin
            n_err++;
            $display("FAIL count_state: run=%b done=%b, want 1/0", m_if.running_o, m_if.done_o);
        end
        pulse_clear();
    endtask

    task automatic test_watch_hit();
        m_if.watch_addr_i = 5'd4;
        m_if.watch_val_i  = 32'd1;
        pulse_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd4) begin
            n_err++;
            $display("FAIL watch_prehit: done=%b cyc=%0d, want 0/4", m_if.done_o, m_if.cycle_cnt_o);
        end
        m_if.wb_en_i = 1'b1; m_if.wb_addr_i = 5'd4; m_if.wb_data_i = 32'd1;
        m_if.retire_i = 1'b1;
        @(negedge clk);
        m_if.wb_en_i = 1'b0;
        n_cmp++;
        if (m_if.done_o !== 1'b1 || m_if.running_o !== 1'b0 ||
            m_if.cycle_cnt_o !== 32'd5 || m_if.instr_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL watch_hit: done=%b run=%b cyc=%0d ins=%0d, want 1/0/5/1",
                     m_if.done_o, m_if.running_o, m_if.cycle_cnt_o, m_if.instr_cnt_o);
        end
        m_if.stall_i = 1'b1; m_if.flush_i = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (m_if.done_o !== 1'b1 || m_if.cycle_cnt_o !== 32'd5 || m_if.instr_cnt_o !== 32'd1 ||
            m_if.stall_cnt_o !== 32'd0 || m_if.flush_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL watch_frozen: done=%b cyc=%0d ins=%0d stl=%0d fl=%0d, want 1/5/1/0/0",
                     m_if.done_o, m_if.cycle_cnt_o, m_if.instr_cnt_o, m_if.stall_cnt_o, m_if.flush_cnt_o);
        end
        idle_inputs();
        pulse_clear();
    endtask

    task automatic test_no_hit();
        m_if.watch_addr_i = 5'd0;
        m_if.watch_val_i  = 32'd0;
        pulse_start();
        m_if.wb_en_i = 1'b1; m_if.wb_addr_i = 5'd0; m_if.wb_data_i = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd3) begin
            n_err++;
            $display("FAIL nohit_x0: run=%b done=%b cyc=%0d, want 1/0/3",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o);
        end
        m_if.watch_addr_i = 5'd4; m_if.watch_val_i = 32'd1;
        m_if.wb_addr_i = 5'd4; m_if.wb_data_i = 32'd2;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd6) begin
            n_err++;
            $display("FAIL nohit_val: run=%b done=%b cyc=%0d, want 1/0/6",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o);
        end
        // retargeting the watch mid-run must hit in the very same cycle
        m_if.watch_val_i = 32'd2;
        @(negedge clk);
        n_cmp++;
        if (m_if.done_o !== 1'b1 || m_if.cycle_cnt_o !== 32'd7) begin
            n_err++;
            $display("FAIL watch_retarget: done=%b cyc=%0d, want 1/7", m_if.done_o, m_if.cycle_cnt_o);
        end
        idle_inputs();
    endtask

    task automatic test_clear_start_done();
        @(negedge clk);
        m_if.clear_i = 1'b1; m_if.start_i = 1'b1;
        @(negedge clk);
        m_if.clear_i = 1'b0; m_if.start_i = 1'b0;
        m_if.retire_i = 1'b1;
        n_cmp++;
        if (m_if.running_o !== 1'b0 || m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL clear_over_start: run=%b done=%b cyc=%0d, want 0/0/0",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (m_if.cycle_cnt_o !== 32'd0 || m_if.instr_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL idle_ignores: cyc=%0d ins=%0d, want 0/0", m_if.cycle_cnt_o, m_if.instr_cnt_o);
        end
        m_if.watch_addr_i = 5'd7; m_if.watch_val_i = 32'hDEAD_BEEF;
        pulse_start();
        m_if.retire_i = 1'b0;
        repeat (2) @(negedge clk);
        m_if.wb_en_i = 1'b1; m_if.wb_addr_i = 5'd7; m_if.wb_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        m_if.wb_en_i = 1'b0;
        n_cmp++;
        if (m_if.done_o !== 1'b1 || m_if.cycle_cnt_o !== 32'd3) begin
            n_err++;
            $display("FAIL redone: done=%b cyc=%0d, want 1/3", m_if.done_o, m_if.cycle_cnt_o);
        end
        pulse_start();
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.done_o !== 1'b0 || m_if.cycle_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL start_in_done: run=%b done=%b cyc=%0d, want 1/0/0",
                     m_if.running_o, m_if.done_o, m_if.cycle_cnt_o);
        end
        m_if.stall_i = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_if.cycle_cnt_o !== 32'd2 || m_if.stall_cnt_o !== 32'd2) begin
            n_err++;
            $display("FAIL restart_count: cyc=%0d stl=%0d, want 2/2", m_if.cycle_cnt_o, m_if.stall_cnt_o);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // start while already running restarts the counts without a gap
        m_if.retire_i = 1'b1;
        m_if.start_i = 1'b1;
        @(negedge clk);
        m_if.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_if.running_o !== 1'b1 || m_if.cycle_cnt_o !== 32'd1 || m_if.instr_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL restart_in_run: run=%b cyc=%0d ins=%0d, want 1/1/1",
                     m_if.running_o, m_if.cycle_cnt_o, m_if.instr_cnt_o);
        end
        idle_inputs();
        pulse_clear();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        sm_start = 1'b1;
        @(negedge clk);
        sm_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 15 || i == 16 || i == 20) begin
                n_cmp++;
                if (s1_if.cycle_cnt_o !== 4'd15) begin
                    n_err++;
                    $display("FAIL sat_cycles@%0d: got %0d, want 15", i, s1_if.cycle_cnt_o);
                end
                n_cmp++;
                if (s0_if.cycle_cnt_o !== 4'(i % 16)) begin
                    n_err++;
                    $display("FAIL wrap_cycles@%0d: got %0d, want %0d", i, s0_if.cycle_cnt_o, i % 16);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        m_if.watch_addr_i = '0;
        m_if.watch_val_i  = '0;
        test_reset();
        test_counting();
        test_watch_hit();
        test_no_hit();
        test_clear_start_done();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
